// File: rtl/risc_intc_pkg.sv
// ---------------------------------------------------------------------------
// risc_intc_pkg
// Shared types and default constants for the RISC interrupt controller.
//   state_t          : controller FSM states (IDLE, REQ, SERVICE)
//   SRC_ID_W         : width of the winning-source index
//   DEF_BASE_VEC     : default handler vector of source 0
//   DEF_VEC_STRIDE   : default spacing between handler vectors
//   DEF_ACK_TIMEOUT  : default cycles spent in REQ before giving up
// ---------------------------------------------------------------------------
package risc_intc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam int          SRC_ID_W        = 3;
  localparam logic [31:0] DEF_BASE_VEC    = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE  = 32'h0000_0010;
  localparam int          DEF_ACK_TIMEOUT = 16;

endpackage

// File: rtl/risc_prio_enc.sv
// ---------------------------------------------------------------------------
// risc_prio_enc
// Combinational fixed-priority encoder; the lowest set index wins.
// Ports:
//   req   in  N         request vector
//   valid out 1         at least one request bit is set
//   idx   out SRC_ID_W  index of the lowest set bit (0 when none set)
// ---------------------------------------------------------------------------
module risc_prio_enc
  import risc_intc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  output logic                  valid,
  output logic [SRC_ID_W-1:0]   idx
);

  // Scan from the top index down so the last hit, the lowest index, sticks.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = SRC_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/risc_intc.sv
// ---------------------------------------------------------------------------
// risc_intc
// Prioritised interrupt controller in front of the RISC core's INT input.
// Collects NUM_SRC requests, masks them, picks the lowest eligible index and
// runs an INT / int_ack / eoi handshake with the core.
//
// Build option: define RISC_INTC_EDGE_TRIG_EN for rising-edge triggered
// sources with sticky pending bits; otherwise sources are level-sensitive.
//
// Ports:
//   clk        in  1        system clock, rising edge
//   rst        in  1        asynchronous reset, active-low
//   irq_src    in  NUM_SRC  peripheral requests
//   mask_wr    in  1        strobe to load mask_wdata into the mask
//   mask_wdata in  NUM_SRC  new mask, 1 = source enabled
//   int_ack    in  1        core accepted the interrupt
//   eoi        in  1        core finished the handler
//   int_out    out 1        INT to the core
//   vec_out    out 32       handler address of the winning source
//   src_id     out 3        winning source index
//   in_service out 1        handler executing
//   irq_count  out 8        serviced interrupts, saturating at 255
// ---------------------------------------------------------------------------
module risc_intc
  import risc_intc_pkg::*;
#(
  parameter int          NUM_SRC     = 4,
  parameter logic [31:0] BASE_VEC    = DEF_BASE_VEC,
  parameter logic [31:0] VEC_STRIDE  = DEF_VEC_STRIDE,
  parameter int          ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   irq_src,
  input  logic                 mask_wr,
  input  logic [NUM_SRC-1:0]   mask_wdata,
  input  logic                 int_ack,
  input  logic                 eoi,
  output logic                 int_out,
  output logic [31:0]          vec_out,
  output logic [SRC_ID_W-1:0]  src_id,
  output logic                 in_service,
  output logic [7:0]           irq_count
);

  localparam int               CNT_W    = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [NUM_SRC-1:0]    mask_q;
  logic [NUM_SRC-1:0]    pending_q;
  logic [NUM_SRC-1:0]    eligible;
  logic                  win_valid;
  logic [SRC_ID_W-1:0]   win_idx;
  logic                  ack_take;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  int_d;
  logic [31:0]           vec_d;
  logic [SRC_ID_W-1:0]   src_d;
  logic                  insvc_d;
  logic [7:0]            count_d;

  assign eligible = pending_q & mask_q;
  assign ack_take = (state_q == REQ) && int_ack;

  risc_prio_enc #(
    .N (NUM_SRC)
  ) u_prio_enc (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Mask register; a write is seen by the arbiter from the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
    end else if (mask_wr) begin
      mask_q <= mask_wdata;
    end
  end

`ifdef RISC_INTC_EDGE_TRIG_EN
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] ack_clr;

  assign rise    = irq_src & ~irq_prev;
  assign ack_clr = ack_take ? (NUM_SRC'(1) << src_id) : '0;

  // Edge-triggered pending: sticky until the source is acknowledged. Masked
  // edges are retained, and a fresh edge in the ack cycle beats the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_prev  <= '0;
      pending_q <= '0;
    end else begin
      irq_prev  <= irq_src;
      pending_q <= (pending_q & ~ack_clr) | rise;
    end
  end
`else
  // Level-sensitive pending simply follows the request lines one cycle late.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= irq_src;
    end
  end
`endif

  // Next-state and next-output logic. Everything visible to the core is
  // computed here and registered below, so all outputs come from flops.
  always_comb begin
    state_d = state_q;
    int_d   = int_out;
    vec_d   = vec_out;
    src_d   = src_id;
    insvc_d = in_service;
    cnt_d   = cnt_q;
    count_d = irq_count;
    unique case (state_q)
      IDLE: begin
        int_d = 1'b0;
        cnt_d = '0;
        if (win_valid) begin
          src_d   = win_idx;
          vec_d   = BASE_VEC + (32'(win_idx) * VEC_STRIDE);
          int_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // The latched request is never pre-empted; only ack or timeout exit,
        // and ack takes precedence when both happen in the same cycle.
        int_d = 1'b1;
        if (ack_take) begin
          int_d   = 1'b0;
          insvc_d = 1'b1;
          cnt_d   = '0;
          count_d = (irq_count == 8'hFF) ? irq_count : irq_count + 8'd1;
          state_d = SERVICE;
        end else if (cnt_q == CNT_LAST) begin
          int_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SERVICE: begin
        int_d = 1'b0;
        if (eoi) begin
          insvc_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        int_d   = 1'b0;
        insvc_d = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, timeout counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      int_out    <= 1'b0;
      vec_out    <= '0;
      src_id     <= '0;
      in_service <= 1'b0;
      irq_count  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_out    <= int_d;
      vec_out    <= vec_d;
      src_id     <= src_d;
      in_service <= insvc_d;
      irq_count  <= count_d;
    end
  end

endmodule

// File: tb/tb_risc_intc.sv
// ---------------------------------------------------------------------------
// tb_risc_intc
// Directed self-checking bench for risc_intc with default parameters.
// The edge-trigger section is compiled only with RISC_INTC_EDGE_TRIG_EN.
// ---------------------------------------------------------------------------
module tb_risc_intc;

  logic        clk;
  logic        rst;
  logic [3:0]  irq_src;
  logic        mask_wr;
  logic [3:0]  mask_wdata;
  logic        int_ack;
  logic        eoi;
  logic        int_out;
  logic [31:0] vec_out;
  logic [2:0]  src_id;
  logic        in_service;
  logic [7:0]  irq_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  risc_intc dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .mask_wr    (mask_wr),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .int_out    (int_out),
    .vec_out    (vec_out),
    .src_id     (src_id),
    .in_service (in_service),
    .irq_count  (irq_count)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then return 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic [3:0] irq, input logic mwr,
                               input logic [3:0] mdata, input logic ack,
                               input logic end_irq);
    irq_src    = irq;
    mask_wr    = mwr;
    mask_wdata = mdata;
    int_ack    = ack;
    eoi        = end_irq;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    rst        = 1'b0;
    irq_src    = '0;
    mask_wr    = 1'b0;
    mask_wdata = '0;
    int_ack    = 1'b0;
    eoi        = 1'b0;
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    $display("[TB] reset released");

    checkOutput("reset_int_out",    32'(int_out),    32'd0);
    checkOutput("reset_vec_out",    vec_out,         32'd0);
    checkOutput("reset_src_id",     32'(src_id),     32'd0);
    checkOutput("reset_in_service", 32'(in_service), 32'd0);
    checkOutput("reset_irq_count",  32'(irq_count),  32'd0);

    // Single source 2: full handshake.
    applyStimulus(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("src2_not_yet", 32'(int_out), 32'd0);
    applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("src2_int_out", 32'(int_out), 32'd1);
    checkOutput("src2_src_id",  32'(src_id),  32'd2);
    checkOutput("src2_vec_out", vec_out,      32'h0000_0120);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("src2_ack_int_out",    32'(int_out),    32'd0);
    checkOutput("src2_ack_in_service", 32'(in_service), 32'd1);
    checkOutput("src2_ack_count",      32'(irq_count),  32'd1);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    checkOutput("src2_eoi_in_service", 32'(in_service), 32'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("src2_idle_int_out", 32'(int_out), 32'd0);

    // Sources 3 and 1 together: 1 wins, then 3 after eoi.
    applyStimulus(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("prio_int_out", 32'(int_out), 32'd1);
    checkOutput("prio_src_id",  32'(src_id),  32'd1);
    checkOutput("prio_vec_out", vec_out,      32'h0000_0110);
    applyStimulus(4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("prio_ack_count", 32'(irq_count), 32'd2);
    applyStimulus(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1);
    checkOutput("prio_eoi_int_out", 32'(int_out), 32'd0);
    applyStimulus(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("src3_int_out", 32'(int_out), 32'd1);
    checkOutput("src3_src_id",  32'(src_id),  32'd3);
    checkOutput("src3_vec_out", vec_out,      32'h0000_0130);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("src3_ack_count", 32'(irq_count), 32'd3);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Masked source stays silent until the mask enables it.
    applyStimulus(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
      checkOutput("masked_int_out", 32'(int_out), 32'd0);
    end
    applyStimulus(4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0);
    checkOutput("unmask_first_cycle", 32'(int_out), 32'd0);
    applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("unmask_int_out", 32'(int_out), 32'd1);
    checkOutput("unmask_src_id",  32'(src_id),  32'd2);

    // No ack: INT is held 16 cycles, drops, then re-arbitrates.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    end
    checkOutput("timeout_still_high", 32'(int_out), 32'd1);
    applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("timeout_drop", 32'(int_out), 32'd0);
    applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("timeout_rearm_int", 32'(int_out),   32'd1);
    checkOutput("timeout_rearm_src", 32'(src_id),    32'd2);
    checkOutput("timeout_count",     32'(irq_count), 32'd3);

    // Ack arriving in the expiry cycle wins over the timeout.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    end
    applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("late_ack_in_service", 32'(in_service), 32'd1);
    checkOutput("late_ack_count",      32'(irq_count),  32'd4);

    // Asynchronous reset while in SERVICE.
    #3 rst = 1'b0;
    #1;
    checkOutput("async_rst_int_out",    32'(int_out),    32'd0);
    checkOutput("async_rst_vec_out",    vec_out,         32'd0);
    checkOutput("async_rst_src_id",     32'(src_id),     32'd0);
    checkOutput("async_rst_in_service", 32'(in_service), 32'd0);
    checkOutput("async_rst_count",      32'(irq_count),  32'd0);
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    end
    checkOutput("post_rst_masked", 32'(int_out), 32'd0);
    applyStimulus(4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("post_rst_int_out", 32'(int_out),   32'd1);
    checkOutput("post_rst_src_id",  32'(src_id),    32'd2);
    checkOutput("post_rst_count",   32'(irq_count), 32'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("post_rst_ack_count", 32'(irq_count), 32'd1);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);

`ifdef RISC_INTC_EDGE_TRIG_EN
    // Edge mode: a masked one-cycle pulse is retained and delivered later;
    // a level held through eoi does not trigger a second interrupt.
    applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("edge_masked_int_out", 32'(int_out), 32'd0);
    applyStimulus(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("edge_int_out", 32'(int_out), 32'd1);
    checkOutput("edge_src_id",  32'(src_id),  32'd0);
    checkOutput("edge_vec_out", vec_out,      32'h0000_0100);
    applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("edge_ack_in_service", 32'(in_service), 32'd1);
    applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("edge_no_retrigger", 32'(int_out), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/risc_intc.md
Name: risc_intc

Overview:
Prioritised interrupt controller that sequences the RISC core's single INT input. It collects NUM_SRC peripheral requests, applies a software-written mask and picks a winner by fixed priority. It then drives INT and a handler vector to the core through a request/acknowledge/end-of-interrupt handshake. It sits between the peripherals and the risc top, in place of a directly driven INT.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..8).
BASE_VEC, 32'h0000_0100, handler vector for source 0.
VEC_STRIDE, 32'h10, vector spacing between sources.
ACK_TIMEOUT, 16, cycles in REQ without int_ack before abandoning (>=2).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
irq_src  in  NUM_SRC  peripheral requests, synchronous to clk.
mask_wr  in  1  one-cycle strobe to load mask.
mask_wdata  in  NUM_SRC  new mask, 1 = source enabled.
int_ack  in  1  core accepted the interrupt (one-cycle pulse).
eoi  in  1  core finished the handler (one-cycle pulse).
int_out  out  1  to core INT.
vec_out  out  32  handler address, valid while int_out=1 and in SERVICE.
src_id  out  3  winning source index.
in_service  out  1  handler executing.
irq_count  out  8  serviced interrupts, saturates at 255.

Behaviour:
- Reset (rst=0, asynchronous) clears everything: int_out=0, vec_out=0, src_id=0, in_service=0, irq_count=0, mask=0 (all disabled), pending=0, state=IDLE, timeout counter=0.
- All outputs are registered.
- mask: loaded from mask_wdata on the clk edge where mask_wr=1. Takes effect on the next arbitration.
- pending[i]: level-sensitive by default, pending = irq_src; edge mode is covered under Optional Feature.
- Eligible requests are pending & mask. Winner is the lowest eligible index.
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If any request is eligible: latch the winner into src_id, set vec_out = BASE_VEC + src_id*VEC_STRIDE (32-bit, wraps), set int_out=1, go to REQ.
  - Latency: int_out rises one edge after pending is seen set.
  - int_ack and eoi are ignored.
- REQ:
  - int_out is held at 1; the timeout counter increments each cycle.
  - On int_ack: int_out=0, in_service=1, irq_count += 1 (saturating), counter cleared, go to SERVICE.
  - If the counter reaches ACK_TIMEOUT-1 with no ack: int_out=0, counter cleared, return to IDLE; pending is kept, so the request re-arbitrates.
  - A mask change or a higher-priority arrival does not pre-empt the latched request.
  - eoi is ignored.
- SERVICE:
  - int_out=0. vec_out and src_id are held.
  - On eoi: in_service=0, go to IDLE. Arbitration resumes the next cycle; no nesting.
  - int_ack is ignored.
  - New requests accumulate in pending.
- Simultaneous int_ack and timeout expiry in the same cycle: the ack wins.
- A reset asserted mid-handshake aborts immediately, with no completion.

Optional Feature:
Macro RISC_INTC_EDGE_TRIG_EN.
- Defined:
  - Sources are rising-edge triggered. An irq_prev register captures the previous irq_src value.
  - pending[i] is set when irq_src[i]=1 and irq_prev[i]=0.
  - pending[src_id] is cleared on the int_ack edge. If a new edge on the same source arrives in that same cycle, set wins.
  - Pending survives masking; masked edges are retained.
- Undefined:
  - Level-sensitive, as above; there is no irq_prev.
  - The peripheral must drop its request before eoi, or it re-triggers.

Decomposition:
- Package risc_intc_pkg holds:
  - state enum {IDLE, REQ, SERVICE};
  - src_id width constant (3);
  - default BASE_VEC, VEC_STRIDE and ACK_TIMEOUT constants.
- One sub-module, risc_prio_enc: combinational lowest-index-first encoder taking a NUM_SRC vector and producing a valid flag and an index.
- The FSM, mask, pending and counters stay in risc_intc.

Test Plan:
- Reset, then write mask=4'b1111 and raise irq_src[2] -> int_out=1 with src_id=2 and vec_out=32'h120. Pulse int_ack -> in_service=1, irq_count=1. Pulse eoi -> back to IDLE.
- Raise irq_src[3] and irq_src[1] in the same cycle -> src_id=1, vec_out=32'h110. After eoi, with src 3 still requesting -> src_id=3, vec_out=32'h130.
- mask=4'b0001 with irq_src[2] high -> int_out stays 0 for 20 cycles. Write mask=4'b0100 -> int_out rises two cycles later.
- Raise a request and never ack -> int_out drops after 16 cycles in REQ, then re-asserts the next cycle with the same src_id. irq_count is unchanged.
- Pulse rst=0 while in SERVICE -> all outputs 0 immediately, without waiting for clk; a request pending before reset does not re-assert until the mask is rewritten.
- With RISC_INTC_EDGE_TRIG_EN defined: pulse irq_src[0] high for 1 cycle while it is masked, then unmask -> interrupt delivered. Hold irq_src[0] high through eoi -> no second interrupt.
